// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake. Single-cycle logic ops and
// iterative one-bit-per-cycle shifts plus a shift-add unsigned multiply.
module alu_seq #(
  parameter  int ancho = 4,
  localparam int CW    = $clog2(ancho + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ancho-1:0] A,
  input  logic [ancho-1:0] B,
  input  logic             ALUFlagIN,
  input  logic [3:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [ancho-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  localparam int M = ancho - 1;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LSL = 4'h8;
  localparam logic [3:0] OP_LSR = 4'h9;
  localparam logic [3:0] OP_SUB = 4'hA;

  localparam logic [ancho-1:0] ONE     = {{(ancho-1){1'b0}}, 1'b1};
  localparam logic [ancho-1:0] MAX_POS = {1'b0, {(ancho-1){1'b1}}};
  localparam logic [ancho-1:0] MIN_NEG = {1'b1, {(ancho-1){1'b0}}};
  localparam logic [ancho-1:0] ANCHO_V = ancho'(ancho);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg;
  logic [3:0]       op_reg;
  logic [ancho-1:0] a_reg;
  logic [ancho-1:0] hi_reg;
  logic [ancho-1:0] lo_reg;
  logic             fill_reg;
  logic [CW-1:0]    cnt_reg;

  logic [ancho:0]   add_sum;
  logic [ancho:0]   sub_diff;
  logic [ancho:0]   inc_sum;
  logic [ancho-1:0] dec_val;
  logic [CW-1:0]    n_amt;

  logic [ancho-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic             sc_multi;
  logic [3:0]       sc_flags;

  logic [ancho-1:0] sh_next;
  logic             sh_cout;
  logic [ancho:0]   mul_sum;
  logic [ancho-1:0] mul_hi_next;
  logic [ancho-1:0] mul_lo_next;
  logic [ancho-1:0] fin_res;
  logic             fin_cv;
  logic             fin_v;
  logic [3:0]       fin_flags;

  assign add_sum  = {1'b0, A} + {1'b0, B} + {{ancho{1'b0}}, ALUFlagIN};
  assign sub_diff = {1'b0, A} - {1'b0, B};
  assign inc_sum  = {1'b0, A} + {1'b0, ONE};
  assign dec_val  = A - ONE;
  // Shifting by more than the width is equivalent to shifting by exactly the width.
  assign n_amt    = (B >= ANCHO_V) ? CW'(ancho) : CW'(B);

  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_multi = 1'b0;
    case (ALUControl)
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_XOR: sc_res = A ^ B;
      OP_NOT: sc_res = ~A;
      OP_ADD: begin
        sc_res = add_sum[ancho-1:0];
        sc_c   = add_sum[ancho];
        sc_v   = (A[M] == B[M]) && (add_sum[M] != A[M]);
      end
      OP_SUB: begin
        sc_res = sub_diff[ancho-1:0];
        sc_c   = ~sub_diff[ancho];
        sc_v   = (A[M] != B[M]) && (sub_diff[M] != A[M]);
      end
      OP_INC: begin
        sc_res = inc_sum[ancho-1:0];
        sc_c   = inc_sum[ancho];
        sc_v   = (A == MAX_POS);
      end
      OP_DEC: begin
        sc_res = dec_val;
        sc_c   = (A != '0);
        sc_v   = (A == MIN_NEG);
      end
      OP_LSL, OP_LSR: begin
        sc_res   = A;
        sc_multi = (n_amt != '0);
      end
      OP_MUL:  sc_multi = 1'b1;
      default: sc_res = '0;
    endcase
  end

  assign sc_flags = {sc_res[M], (sc_res == '0), sc_c, sc_v};

  // Next iteration values; on the final RUN cycle these are what gets written out.
  always_comb begin
    if (op_reg == OP_LSL) begin
      sh_next = {lo_reg[ancho-2:0], fill_reg};
      sh_cout = lo_reg[M];
    end else begin
      sh_next = {fill_reg, lo_reg[ancho-1:1]};
      sh_cout = lo_reg[0];
    end
  end

  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(ancho+1){1'b0}});
  assign mul_hi_next = mul_sum[ancho:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[ancho-1:1]};

  always_comb begin
    if (op_reg == OP_MUL) begin
      fin_res = mul_lo_next;
      fin_cv  = (mul_hi_next != '0);
      fin_v   = (mul_hi_next != '0);
    end else begin
      fin_res = sh_next;
      fin_cv  = sh_cout;
      fin_v   = 1'b0;
    end
  end

  assign fin_flags = {fin_res[M], (fin_res == '0), fin_cv, fin_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      fill_reg  <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ALUResult <= '0;
      ALUFlags  <= '0;
    end else begin
      case (state_reg)
        // FIN only exists to present done with busy low; it accepts like IDLE.
        IDLE, FIN: begin
          done      <= 1'b0;
          state_reg <= IDLE;
          if (start) begin
            if (sc_multi) begin
              op_reg    <= ALUControl;
              a_reg     <= A;
              fill_reg  <= ALUFlagIN;
              hi_reg    <= '0;
              lo_reg    <= (ALUControl == OP_MUL) ? B : A;
              cnt_reg   <= (ALUControl == OP_MUL) ? CW'(ancho) : n_amt;
              busy      <= 1'b1;
              state_reg <= RUN;
            end else begin
              ALUResult <= sc_res;
              ALUFlags  <= sc_flags;
              done      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (op_reg == OP_MUL) begin
            hi_reg <= mul_hi_next;
            lo_reg <= mul_lo_next;
          end else begin
            lo_reg <= sh_next;
          end
          if (cnt_reg == ONE[CW-1:0]) begin
            ALUResult <= fin_res;
            ALUFlags  <= fin_flags;
            done      <= 1'b1;
            busy      <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= FIN;
          end else begin
            cnt_reg <= cnt_reg - ONE[CW-1:0];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
